// File: rtl/systolic_matmul_if.sv
// Operand/result bus for the systolic matrix multiplier: job request, operands, status and result.
interface systolic_matmul_if #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(N)
);
    localparam int unsigned CW = $clog2(3 * N);

    logic                    start_i;
    logic                    signed_i;
    logic [N*N*DATA_W-1:0]   mat_a_i;
    logic [N*N*DATA_W-1:0]   mat_b_i;
    logic                    busy_o;
    logic                    done_o;
    logic [N*N*ACC_W-1:0]    result_o;
    logic                    overflow_o;
    logic [CW-1:0]           cycle_o;

    modport slave (
        input  start_i, signed_i, mat_a_i, mat_b_i,
        output busy_o, done_o, result_o, overflow_o, cycle_o
    );

    modport master (
        output start_i, signed_i, mat_a_i, mat_b_i,
        input  busy_o, done_o, result_o, overflow_o, cycle_o
    );
endinterface

// File: rtl/systolic_matmul_core.sv
// NxN output-stationary systolic matrix multiplier C = A x B with start/busy/done handshake.
// Optional SYSTOLIC_SATURATE_EN: clamp accumulators to ACC_W range and flag sticky overflow.
module systolic_matmul_core #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(N)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    systolic_matmul_if.slave   bus
);
    localparam int unsigned CW = $clog2(3 * N);
    localparam int unsigned PW = 2 * DATA_W;
    localparam logic [CW-1:0] LAST_STEP = CW'(3 * N - 3);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                 state_q, state_d;
    logic                   busy_q, done_q;
    logic                   start_accept;

    logic [N*N*DATA_W-1:0]  mat_a_q, mat_b_q;
    logic                   signed_q;
    logic [CW-1:0]          cycle_q;
    logic [N*N*ACC_W-1:0]   result_q;

    logic [DATA_W-1:0]      a_edge [N];
    logic [DATA_W-1:0]      b_edge [N];
    logic [DATA_W-1:0]      a_pipe [N][N-1];
    logic [DATA_W-1:0]      b_pipe [N-1][N];
    logic [DATA_W-1:0]      a_op   [N][N];
    logic [DATA_W-1:0]      b_op   [N][N];
    logic [ACC_W-1:0]       acc_q  [N][N];
    logic [ACC_W-1:0]       acc_d  [N][N];
`ifdef SYSTOLIC_SATURATE_EN
    logic [N*N-1:0]         clamp;
    logic                   overflow_q;
`endif

    // Full-precision product, extended to accumulator width per operand mode.
    function automatic logic [ACC_W-1:0] ext_product(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b,
                                                     input logic sgn);
        logic [PW-1:0]    p;
        logic [ACC_W-1:0] r;
        if (sgn) begin
            p = PW'($signed(a) * $signed(b));
            r = ACC_W'($signed(p));
        end else begin
            p = PW'(a) * PW'(b);
            r = ACC_W'(p);
        end
        return r;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d      = state_q;
        start_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d      = RUN;
                    start_accept = 1'b1;
                end
            end
            RUN: begin
                if (cycle_q == LAST_STEP) state_d = DONE;
            end
            DONE: begin
                if (bus.start_i) begin
                    state_d      = RUN;
                    start_accept = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Skewed boundary feed: row i and column j enter the array i/j steps late.
    always_comb begin
        int k;
        for (int i = 0; i < int'(N); i++) begin
            k         = int'(cycle_q) - i;
            a_edge[i] = '0;
            b_edge[i] = '0;
            if (k >= 0 && k < int'(N)) begin
                a_edge[i] = mat_a_q[(i * int'(N) + k) * int'(DATA_W) +: DATA_W];
                b_edge[i] = mat_b_q[(k * int'(N) + i) * int'(DATA_W) +: DATA_W];
            end
        end
    end

    for (genvar i = 0; i < int'(N); i++) begin : g_row
        for (genvar j = 0; j < int'(N); j++) begin : g_col
            if (j == 0) begin : g_a_edge
                assign a_op[i][j] = a_edge[i];
            end else begin : g_a_fwd
                assign a_op[i][j] = a_pipe[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_op[i][j] = b_edge[j];
            end else begin : g_b_fwd
                assign b_op[i][j] = b_pipe[i-1][j];
            end
`ifdef SYSTOLIC_SATURATE_EN
            logic [ACC_W-1:0] prod;
            logic [ACC_W:0]   sum;
            logic [ACC_W-1:0] acc_nxt;
            logic             clamp_pe;
            // One guard bit detects leaving the representable range.
            always_comb begin
                prod     = ext_product(a_op[i][j], b_op[i][j], signed_q);
                sum      = '0;
                clamp_pe = 1'b0;
                if (signed_q) begin
                    sum     = {acc_q[i][j][ACC_W-1], acc_q[i][j]} + {prod[ACC_W-1], prod};
                    acc_nxt = sum[ACC_W-1:0];
                    if (sum[ACC_W] != sum[ACC_W-1]) begin
                        clamp_pe = 1'b1;
                        acc_nxt  = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                              : {1'b0, {(ACC_W-1){1'b1}}};
                    end
                end else begin
                    sum     = {1'b0, acc_q[i][j]} + {1'b0, prod};
                    acc_nxt = sum[ACC_W-1:0];
                    if (sum[ACC_W]) begin
                        clamp_pe = 1'b1;
                        acc_nxt  = '1;
                    end
                end
            end
            assign acc_d[i][j]    = acc_nxt;
            assign clamp[i*N + j] = clamp_pe;
`else
            assign acc_d[i][j] = acc_q[i][j] + ext_product(a_op[i][j], b_op[i][j], signed_q);
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mat_a_q  <= '0;
            mat_b_q  <= '0;
            signed_q <= 1'b0;
            cycle_q  <= '0;
            result_q <= '0;
            for (int i = 0; i < int'(N); i++)
                for (int j = 0; j < int'(N); j++) acc_q[i][j] <= '0;
            for (int i = 0; i < int'(N); i++)
                for (int j = 0; j < int'(N) - 1; j++) a_pipe[i][j] <= '0;
            for (int i = 0; i < int'(N) - 1; i++)
                for (int j = 0; j < int'(N); j++) b_pipe[i][j] <= '0;
`ifdef SYSTOLIC_SATURATE_EN
            overflow_q <= 1'b0;
`endif
        end else if (start_accept) begin
            mat_a_q  <= bus.mat_a_i;
            mat_b_q  <= bus.mat_b_i;
            signed_q <= bus.signed_i;
            cycle_q  <= '0;
            for (int i = 0; i < int'(N); i++)
                for (int j = 0; j < int'(N); j++) acc_q[i][j] <= '0;
            for (int i = 0; i < int'(N); i++)
                for (int j = 0; j < int'(N) - 1; j++) a_pipe[i][j] <= '0;
            for (int i = 0; i < int'(N) - 1; i++)
                for (int j = 0; j < int'(N); j++) b_pipe[i][j] <= '0;
`ifdef SYSTOLIC_SATURATE_EN
            overflow_q <= 1'b0;
`endif
        end else if (state_q == RUN) begin
            for (int i = 0; i < int'(N); i++)
                for (int j = 0; j < int'(N); j++) acc_q[i][j] <= acc_d[i][j];
            for (int i = 0; i < int'(N); i++)
                for (int j = 0; j < int'(N) - 1; j++) a_pipe[i][j] <= a_op[i][j];
            for (int i = 0; i < int'(N) - 1; i++)
                for (int j = 0; j < int'(N); j++) b_pipe[i][j] <= b_op[i][j];
`ifdef SYSTOLIC_SATURATE_EN
            overflow_q <= overflow_q | (|clamp);
`endif
            // Final step's sums go straight into the result register.
            if (cycle_q == LAST_STEP) begin
                for (int i = 0; i < int'(N); i++)
                    for (int j = 0; j < int'(N); j++)
                        result_q[(i * int'(N) + j) * int'(ACC_W) +: ACC_W] <= acc_d[i][j];
            end else begin
                cycle_q <= cycle_q + CW'(1);
            end
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
    assign bus.cycle_o  = cycle_q;
`ifdef SYSTOLIC_SATURATE_EN
    assign bus.overflow_o = overflow_q;
`else
    assign bus.overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_matmul_core.sv
// Randomized self-checking bench for systolic_matmul_core against a plain-arithmetic matrix model.
module tb_systolic_matmul_core;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    systolic_matmul_if #(.N(4), .DATA_W(4))             if0 ();
    systolic_matmul_if #(.N(4), .DATA_W(4), .ACC_W(8))  if1 ();
    systolic_matmul_if #(.N(2), .DATA_W(4))             if2 ();
    systolic_matmul_if #(.N(8), .DATA_W(6))             if3 ();

    systolic_matmul_core #(.N(4), .DATA_W(4))            u0 (.clk_i(clk), .rst_ni(rst_n), .bus(if0));
    systolic_matmul_core #(.N(4), .DATA_W(4), .ACC_W(8)) u1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1));
    systolic_matmul_core #(.N(2), .DATA_W(4))            u2 (.clk_i(clk), .rst_ni(rst_n), .bus(if2));
    systolic_matmul_core #(.N(8), .DATA_W(6))            u3 (.clk_i(clk), .rst_ni(rst_n), .bus(if3));

    int checks   = 0;
    int failures = 0;
    int ga [8][8];
    int gb [8][8];

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int dut_n(input int d);
        case (d) 0: return 4; 1: return 4; 2: return 2; default: return 8; endcase
    endfunction
    function automatic int dut_dw(input int d);
        return (d == 3) ? 6 : 4;
    endfunction
    function automatic int dut_aw(input int d);
        case (d) 0: return 10; 1: return 8; 2: return 9; default: return 15; endcase
    endfunction

    // Reference: C[r][c] = sum_k A[r][k]*B[k][c], accumulated in k order.
    function automatic longint model(input int d, input bit sg, input int r, input int c,
                                     output bit ovf);
        int     n  = dut_n(d);
        int     dw = dut_dw(d);
        int     aw = dut_aw(d);
        longint acc = 0;
        longint av, bv, mask;
        ovf  = 1'b0;
        mask = (longint'(1) << aw) - 1;
        for (int k = 0; k < n; k++) begin
            av = ga[r][k];
            bv = gb[k][c];
            if (sg) begin
                if (av >= (longint'(1) << (dw - 1))) av -= (longint'(1) << dw);
                if (bv >= (longint'(1) << (dw - 1))) bv -= (longint'(1) << dw);
            end
            acc += av * bv;
`ifdef SYSTOLIC_SATURATE_EN
            begin
                longint lo, hi;
                lo = sg ? -(longint'(1) << (aw - 1)) : 0;
                hi = sg ? (longint'(1) << (aw - 1)) - 1 : mask;
                if (acc > hi) begin acc = hi; ovf = 1'b1; end
                else if (acc < lo) begin acc = lo; ovf = 1'b1; end
            end
`endif
        end
        return acc & mask;
    endfunction

    task automatic set_mats(input int d);
        case (d)
            0: for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
                   if0.mat_a_i[(r*4+c)*4 +: 4] = 4'(ga[r][c]);
                   if0.mat_b_i[(r*4+c)*4 +: 4] = 4'(gb[r][c]);
               end
            1: for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
                   if1.mat_a_i[(r*4+c)*4 +: 4] = 4'(ga[r][c]);
                   if1.mat_b_i[(r*4+c)*4 +: 4] = 4'(gb[r][c]);
               end
            2: for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) begin
                   if2.mat_a_i[(r*2+c)*4 +: 4] = 4'(ga[r][c]);
                   if2.mat_b_i[(r*2+c)*4 +: 4] = 4'(gb[r][c]);
               end
            default: for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) begin
                   if3.mat_a_i[(r*8+c)*6 +: 6] = 6'(ga[r][c]);
                   if3.mat_b_i[(r*8+c)*6 +: 6] = 6'(gb[r][c]);
               end
        endcase
    endtask

    task automatic set_ctl(input int d, input logic st, input logic sg);
        case (d)
            0: begin if0.start_i = st; if0.signed_i = sg; end
            1: begin if1.start_i = st; if1.signed_i = sg; end
            2: begin if2.start_i = st; if2.signed_i = sg; end
            default: begin if3.start_i = st; if3.signed_i = sg; end
        endcase
    endtask

    function automatic logic get_done(input int d);
        case (d) 0: return if0.done_o; 1: return if1.done_o; 2: return if2.done_o;
            default: return if3.done_o; endcase
    endfunction
    function automatic logic get_busy(input int d);
        case (d) 0: return if0.busy_o; 1: return if1.busy_o; 2: return if2.busy_o;
            default: return if3.busy_o; endcase
    endfunction
    function automatic logic get_ovf(input int d);
        case (d) 0: return if0.overflow_o; 1: return if1.overflow_o; 2: return if2.overflow_o;
            default: return if3.overflow_o; endcase
    endfunction
    function automatic int get_cycle(input int d);
        case (d) 0: return int'(if0.cycle_o); 1: return int'(if1.cycle_o);
            2: return int'(if2.cycle_o); default: return int'(if3.cycle_o); endcase
    endfunction
    function automatic longint get_res(input int d, input int r, input int c);
        case (d)
            0: return longint'(if0.result_o[(r*4+c)*10 +: 10]);
            1: return longint'(if1.result_o[(r*4+c)*8 +: 8]);
            2: return longint'(if2.result_o[(r*2+c)*9 +: 9]);
            default: return longint'(if3.result_o[(r*8+c)*15 +: 15]);
        endcase
    endfunction

    task automatic fill_rand(input int d);
        int hi = (1 << dut_dw(d)) - 1;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                ga[r][c] = int'($urandom_range(0, hi));
                gb[r][c] = int'($urandom_range(0, hi));
            end
    endtask

    // Drives garbage onto the operand bus without disturbing the model's matrices.
    task automatic scramble_bus(input int d);
        int sa [8][8];
        int sb [8][8];
        sa = ga; sb = gb;
        fill_rand(d);
        set_mats(d);
        ga = sa; gb = sb;
    endtask

    task automatic compare_res(input int d, input bit sg, input string tag);
        bit     ovf_exp = 1'b0;
        bit     oe;
        longint exp;
        for (int r = 0; r < dut_n(d); r++)
            for (int c = 0; c < dut_n(d); c++) begin
                exp = model(d, sg, r, c, oe);
                ovf_exp |= oe;
                check($sformatf("%s_c%0d_%0d", tag, r, c), get_res(d, r, c), exp);
            end
        check({tag, "_ovf"}, longint'(get_ovf(d)), longint'(ovf_exp));
    endtask

    // Called at the negedge right after the start edge with start_i already low.
    task automatic finish_job(input int d, input bit sg, input string tag);
        int edges = 1;
        check({tag, "_busy"}, longint'(get_busy(d)), 1);
        check({tag, "_cyc0"}, get_cycle(d), 0);
        while (!get_done(d) && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "_latency"}, edges, 3 * dut_n(d) - 1);
        compare_res(d, sg, tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, longint'(get_done(d)), 0);
        check({tag, "_idle"}, longint'(get_busy(d)), 0);
    endtask

    task automatic run_job(input int d, input bit sg, input string tag);
        @(negedge clk);
        set_mats(d);
        set_ctl(d, 1'b1, sg);
        @(negedge clk);
        set_ctl(d, 1'b0, ~sg);
        scramble_bus(d);
        finish_job(d, sg, tag);
    endtask

    task automatic load_ref_vector();
        int rows [4][4] = '{'{0, 2, 3, 4}, '{5, 6, 7, 8}, '{9, 10, 11, 12}, '{13, 14, 15, 15}};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ga[r][c] = rows[r][c];
                gb[r][c] = rows[r][c];
            end
        gb[0][0] = 1;
    endtask

    task automatic fill_const(input int av, input int bv);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                ga[r][c] = av;
                gb[r][c] = bv;
            end
    endtask

    initial begin
        int  edges, dones, cyc_wait;
        bit  sg;

        rst_n = 1'b0;
        for (int d = 0; d < 4; d++) begin
            fill_const(0, 0);
            set_mats(d);
            set_ctl(d, 1'b0, 1'b0);
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("rst_busy%0d", d), longint'(get_busy(d)), 0);
            check($sformatf("rst_done%0d", d), longint'(get_done(d)), 0);
            check($sformatf("rst_ovf%0d", d), longint'(get_ovf(d)), 0);
            check($sformatf("rst_cyc%0d", d), get_cycle(d), 0);
            check($sformatf("rst_res%0d", d), get_res(d, 0, 0), 0);
        end
        rst_n = 1'b1;

        load_ref_vector();
        run_job(0, 1'b0, "ref");
        check("ref_c00_const", get_res(0, 0, 0), 89);
        check("ref_c33_const", get_res(0, 3, 3), 569);

        fill_const(15, 1);
        run_job(0, 1'b1, "neg");
        check("neg_const", get_res(0, 1, 2), 1020);
        run_job(0, 1'b0, "pos");
        check("pos_const", get_res(0, 2, 1), 60);

        fill_const(15, 15);
        run_job(1, 1'b0, "narrow");
`ifdef SYSTOLIC_SATURATE_EN
        check("narrow_const", get_res(1, 0, 0), 255);
        check("narrow_ovf_const", longint'(get_ovf(1)), 1);
`else
        check("narrow_const", get_res(1, 0, 0), 132);
        check("narrow_ovf_const", longint'(get_ovf(1)), 0);
`endif

        for (int t = 0; t < 4; t++) begin
            sg = 1'($urandom_range(0, 1));
            fill_rand(0); run_job(0, sg, $sformatf("rnd4_%0d", t));
            sg = 1'($urandom_range(0, 1));
            fill_rand(2); run_job(2, sg, $sformatf("rnd2_%0d", t));
            sg = 1'($urandom_range(0, 1));
            fill_rand(1); run_job(1, sg, $sformatf("rnd4n_%0d", t));
        end
        for (int t = 0; t < 3; t++) begin
            sg = 1'($urandom_range(0, 1));
            fill_rand(3); run_job(3, sg, $sformatf("rnd8_%0d", t));
        end

        // Abort a running job with reset.
        load_ref_vector();
        @(negedge clk);
        set_mats(0);
        set_ctl(0, 1'b1, 1'b0);
        @(negedge clk);
        set_ctl(0, 1'b0, 1'b0);
        cyc_wait = 0;
        while (get_cycle(0) != 5 && cyc_wait < 20) begin
            @(negedge clk);
            cyc_wait++;
        end
        check("abort_reach_cyc5", get_cycle(0), 5);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", longint'(get_busy(0)), 0);
        check("abort_done", longint'(get_done(0)), 0);
        check("abort_cyc", get_cycle(0), 0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                check($sformatf("abort_res%0d_%0d", r, c), get_res(0, r, c), 0);
        rst_n = 1'b1;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (get_done(0)) dones++;
        end
        check("abort_no_done", dones, 0);

        // start_i held through DONE launches the next job without passing IDLE.
        load_ref_vector();
        @(negedge clk);
        set_mats(0);
        set_ctl(0, 1'b1, 1'b0);
        edges = 0;
        while (!get_done(0) && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        check("b2b_first_latency", edges, 11);
        compare_res(0, 1'b0, "b2b_first");
        fill_rand(0);
        set_mats(0);
        set_ctl(0, 1'b1, 1'b1);
        @(negedge clk);
        set_ctl(0, 1'b0, 1'b0);
        check("b2b_no_second_done", longint'(get_done(0)), 0);
        finish_job(0, 1'b1, "b2b_second");

        // start_i pulsed mid-run must be ignored.
        load_ref_vector();
        @(negedge clk);
        set_mats(0);
        set_ctl(0, 1'b1, 1'b0);
        @(negedge clk);
        set_ctl(0, 1'b0, 1'b0);
        edges = 1;
        repeat (2) begin @(negedge clk); edges++; end
        scramble_bus(0);
        set_ctl(0, 1'b1, 1'b1);
        @(negedge clk);
        edges++;
        set_ctl(0, 1'b0, 1'b0);
        while (!get_done(0) && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        check("ign_latency", edges, 11);
        compare_res(0, 1'b0, "ign");
        dones = 0;
        repeat (16) begin
            @(negedge clk);
            if (get_done(0)) dones++;
        end
        check("ign_single_done", dones, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
